// File: rtl/snake_tick_ctrl.sv
// rtl/snake_tick_ctrl.sv - game-step tick generator with speed levels for a snake game
//
// Ports:
//   clk          : sole clock, all state updates on the rising edge
//   reset        : asynchronous active-low reset
//   start        : level-sampled start/restart request (IDLE/OVER only)
//   pause_toggle : one-cycle pulse toggling RUN <-> PAUSED
//   food_eaten   : one-cycle pulse per food consumed (RUN only)
//   game_over    : one-cycle pulse ending the game (RUN/PAUSED)
//   tick         : registered one-cycle game-step strobe
//   level        : current speed level, saturating at MAX_LEVEL
//   state        : IDLE=00, RUN=01, PAUSED=10, OVER=11

module snake_tick_ctrl #(
   parameter int BASE_PERIOD    = 2500000,
   parameter int STEP           = 250000,
   parameter int MAX_LEVEL      = 7,
   parameter int FOOD_PER_LEVEL = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           pause_toggle,
   input  logic                           food_eaten,
   input  logic                           game_over,
   output logic                           tick,
   output logic [$clog2(MAX_LEVEL+1)-1:0] level,
   output logic [1:0]                     state
);

   localparam int LW = $clog2(MAX_LEVEL + 1);
   localparam int CW = $clog2(BASE_PERIOD);
   // A single food per level would give a zero-width counter; keep one bit.
   localparam int FW = (FOOD_PER_LEVEL > 1) ? $clog2(FOOD_PER_LEVEL) : 1;

   // The shortest period must stay positive, otherwise the game stalls.
   if (BASE_PERIOD <= MAX_LEVEL * STEP) begin : g_bad_params
      $error("snake_tick_ctrl: BASE_PERIOD must exceed MAX_LEVEL*STEP");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10,
      S_OVER   = 2'b11
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [CW-1:0]   r_count;
   logic [FW-1:0]   r_food;
   logic [LW-1:0]   r_level;
   logic            r_tick;

   logic [31:0]     w_period_m1;
   logic            w_terminal;
   logic            w_start;
   logic            w_run_stay;
   logic            w_food_take;

   // Full 32-bit arithmetic so the period is never truncated.
   assign w_period_m1 = 32'(BASE_PERIOD) - 32'(r_level) * 32'(STEP) - 32'd1;
   // >= rather than == : a level-up that drops the period below the current
   // count must still tick on the next edge instead of wrapping the counter.
   assign w_terminal  = (32'(r_count) >= w_period_m1);

   assign w_start     = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;
   assign w_run_stay  = (r_state == S_RUN) && !game_over && !pause_toggle;
   // Food still counts when it coincides with a pause request, but not with game_over.
   assign w_food_take = (r_state == S_RUN) && !game_over && food_eaten;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (start) w_next_state = S_RUN;
         end
         S_RUN: begin
            if (game_over)         w_next_state = S_OVER;
            else if (pause_toggle) w_next_state = S_PAUSED;
         end
         S_PAUSED: begin
            if (game_over)         w_next_state = S_OVER;
            else if (pause_toggle) w_next_state = S_RUN;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_food  <= '0;
         r_level <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (w_start) begin
            r_count <= '0;
            r_food  <= '0;
            r_level <= '0;
         end else begin
            // Counter only moves while staying in RUN; pause holds it.
            if (w_run_stay) begin
               if (w_terminal) begin
                  r_count <= '0;
                  r_tick  <= 1'b1;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            // Level update uses the pre-edge level for the compare above.
            if (w_food_take) begin
               if (r_food == FW'(FOOD_PER_LEVEL - 1)) begin
                  r_food <= '0;
                  if (r_level != LW'(MAX_LEVEL)) r_level <= r_level + LW'(1);
               end else begin
                  r_food <= r_food + FW'(1);
               end
            end
         end
      end
   end

   assign tick  = r_tick;
   assign level = r_level;
   assign state = r_state;

endmodule

// File: doc/snake_tick_ctrl.md
SNAKE_TICK_CTRL -- requirements
Module: snake_tick_ctrl

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 2500000, cycles per game tick at level 0.
REQ-002 SHALL have parameter STEP, default 250000, period reduction per speed level.
REQ-003 SHALL have parameter MAX_LEVEL, default 7, saturating top speed level.
REQ-004 SHALL have parameter FOOD_PER_LEVEL, default 4, food events needed per level-up.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, level-sampled start/restart request.
REQ-008 SHALL have port pause_toggle, input, 1, one-cycle pulse toggling pause.
REQ-009 SHALL have port food_eaten, input, 1, one-cycle pulse per food consumed.
REQ-010 SHALL have port game_over, input, 1, one-cycle pulse ending the game.
REQ-011 SHALL have port tick, output, 1, registered one-cycle game-step strobe.
REQ-012 SHALL have port level, output, $clog2(MAX_LEVEL+1), current speed level.
REQ-013 SHALL have port state, output, 2, FSM state: IDLE=00, RUN=01, PAUSED=10, OVER=11.

Function
REQ-014 SHALL hold an internal period counter, width $clog2(BASE_PERIOD), and a food counter, width $clog2(FOOD_PER_LEVEL).
REQ-015 SHALL compute period = BASE_PERIOD - level*STEP without truncation; elaboration SHALL fail if BASE_PERIOD <= MAX_LEVEL*STEP.
REQ-016 IDLE or OVER with start=1 SHALL go to RUN and clear period counter, food counter and level to 0; start SHALL be ignored in RUN and PAUSED.
REQ-017 In RUN, each edge: if count >= period-1, count <= 0 and tick <= 1; else count <= count+1 and tick <= 0.
REQ-018 The >= compare SHALL make a level-up that shortens the period below the current count tick on the next edge, never wrapping the counter.
REQ-019 tick SHALL be 0 in every cycle not following a terminal-count edge in RUN; never high two consecutive cycles.
REQ-020 RUN with pause_toggle=1 SHALL go to PAUSED; PAUSED with pause_toggle=1 SHALL go to RUN; counter SHALL hold, not clear, across pause.
REQ-021 Counter SHALL advance only on edges where state (pre-edge) is RUN and no transition out of RUN occurs.
REQ-022 food_eaten in RUN SHALL increment food counter; at FOOD_PER_LEVEL-1 it SHALL instead clear to 0 and increment level, saturating at MAX_LEVEL (food counter still clears).
REQ-023 food_eaten SHALL be ignored in IDLE, PAUSED and OVER.
REQ-024 game_over in RUN or PAUSED SHALL go to OVER; counter, level held; no tick generated on that edge.
REQ-025 Priority on simultaneous inputs in RUN: game_over > pause_toggle > food_eaten/terminal count; a losing pause_toggle is dropped, a food_eaten coincident with pause_toggle is still counted.
REQ-026 Level change and terminal-count compare on the same edge SHALL use the pre-edge level.
REQ-027 OVER SHALL hold level visible until start.

Reset
REQ-028 reset=0 SHALL immediately, without clk, force state=IDLE, tick=0, level=0, period and food counters 0.
REQ-029 Reset asserted mid-RUN SHALL abort any pending tick; after release block SHALL remain IDLE until start.

Verification (BASE_PERIOD=20, STEP=2, MAX_LEVEL=3, FOOD_PER_LEVEL=2)
REQ-030 start sampled at edge E0 -> state=RUN after E0; tick high after E20, E40, E60, one cycle each.
REQ-031 two food_eaten pulses in RUN -> level=1, tick spacing 18; eight pulses -> level=3 saturated, spacing 14.
REQ-032 pause_toggle sampled with count=5, hold 30 cycles, pause_toggle again at edge R -> no tick while PAUSED; next tick after edge R+15.
REQ-033 second food pulse sampled with count=18 at level 0 -> level=1 and count=19 after that edge; tick after next edge, count=0.
REQ-034 game_over coincident with count=19 -> state=OVER, tick stays 0, level held; start -> RUN, level=0.
REQ-035 reset pulled low asynchronously mid-RUN with count=10, level=2 -> outputs 0/IDLE before next clk edge; stays IDLE after release until start.
